// File: rtl/perip_bcd_bin_conv.sv
// perip_bcd_bin_conv: bidirectional BCD<->binary converter peripheral on the j1 I/O bus.
// A serial engine handles one bit per clock: shift-right/subtract-3 for BCD->binary and
// add-3/shift-left for binary->BCD. Invalid BCD digits and binary overflow are reported as errors.
// Optional feature macro: BCDBIN_IRQ_EN adds the IRQ_EN register and the completion interrupt.
// Bus protocol: a register access happens on any rising edge where cs is high; wr selects a write
// and rd a read. There is no wait state; read data appears on d_out one edge later.
module perip_bcd_bin_conv #(
    parameter int DIGITS = 8,
    parameter int BIN_W  = 27
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] d_in,
    input  logic        cs,
    input  logic [4:0]  addr,
    input  logic        rd,
    input  logic        wr,
    output logic [31:0] d_out,
    output logic        irq
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int BW    = (BCD_W > BIN_W) ? BCD_W : BIN_W;
    localparam int CNT_W = $clog2(BW + 1);
    localparam logic [CNT_W-1:0] LAST_BCD = CNT_W'(BCD_W - 1);
    localparam logic [CNT_W-1:0] LAST_BIN = CNT_W'(BIN_W - 1);

    localparam logic [4:0] A_DATA   = 5'h04;
    localparam logic [4:0] A_MODE   = 5'h08;
    localparam logic [4:0] A_CTRL   = 5'h0C;
    localparam logic [4:0] A_RESULT = 5'h10;
    localparam logic [4:0] A_STATUS = 5'h14;
    localparam logic [4:0] A_IRQEN  = 5'h18;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

    // Smallest binary operand that no longer fits into DIGITS BCD digits.
    localparam logic [63:0] BIN_LIMIT = pow10(DIGITS);

    function automatic logic [BCD_W-1:0] bcd_add3(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++)
            if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
        return r;
    endfunction

    function automatic logic [BCD_W-1:0] bcd_sub3(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++)
            if (v[4*i +: 4] >= 4'd8) r[4*i +: 4] = v[4*i +: 4] - 4'd3;
        return r;
    endfunction

    function automatic logic bcd_invalid(input logic [BCD_W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            if (v[4*i +: 4] > 4'd9) bad = 1'b1;
        return bad;
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_CONV, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [31:0]       data_in_q, data_in_d;
    logic              mode_q, mode_d;
    logic              wmode_q, wmode_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d;
    logic [BW-1:0]     bin_q, bin_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       result_q, result_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [31:0]       d_out_q, d_out_d;
    logic              wr_en, rd_en, idle, start;
    logic [31:0]       status;
    logic [BCD_W-1:0]  bcd_adj;

    assign wr_en  = cs & wr;
    assign rd_en  = cs & rd;
    assign idle   = (state_q == S_IDLE);
    assign start  = wr_en && (addr == A_CTRL) && d_in[0] && idle;
    assign status = {29'd0, err_q, ~idle, done_q};

    // Register writes, conversion FSM and serial datapath next-state logic.
    always_comb begin
        state_d   = state_q;
        data_in_d = data_in_q;
        mode_d    = mode_q;
        wmode_d   = wmode_q;
        bcd_d     = bcd_q;
        bin_d     = bin_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        done_d    = done_q;
        err_d     = err_q;
        bcd_adj   = '0;

        // Operand and direction are frozen while a conversion is in flight.
        if (wr_en && idle) begin
            if (addr == A_DATA) data_in_d = d_in;
            if (addr == A_MODE) mode_d = d_in[0];
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    wmode_d = mode_q;
                    if (mode_q) begin
                        bcd_d = '0;
                        bin_d = BW'(data_in_q[BIN_W-1:0]);
                    end else begin
                        bcd_d = data_in_q[BCD_W-1:0];
                        bin_d = '0;
                    end
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (wmode_q ? (64'(bin_q[BIN_W-1:0]) >= BIN_LIMIT) : bcd_invalid(bcd_q)) begin
                    err_d    = 1'b1;
                    result_d = '0;
                    state_d  = S_DONE;
                end else begin
                    cnt_d   = wmode_q ? LAST_BIN : LAST_BCD;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                if (wmode_q) begin
                    bcd_adj = bcd_add3(bcd_q);
                    bcd_d   = {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
                    bin_d   = bin_q << 1;
                end else begin
                    bcd_d            = bcd_sub3(bcd_q >> 1);
                    bin_d            = bin_q >> 1;
                    bin_d[BCD_W-1]   = bcd_q[0];
                end
                if (cnt_q == '0) state_d = S_DONE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_DONE: begin
                if (!err_q) result_d = wmode_q ? 32'(bcd_q) : 32'(bin_q[BIN_W-1:0]);
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef BCDBIN_IRQ_EN
    logic irq_en_q, irq_en_d;
    logic irq_q, irq_d;

    // Interrupt enable register and sticky completion interrupt.
    always_comb begin
        irq_en_d = irq_en_q;
        irq_d    = irq_q;
        if (wr_en && (addr == A_IRQEN)) irq_en_d = d_in[0];
        if ((rd_en && (addr == A_STATUS)) || start || (wr_en && (addr == A_IRQEN) && !d_in[0]))
            irq_d = 1'b0;
        if ((state_q == S_DONE) && irq_en_q) irq_d = 1'b1;
    end

    // Interrupt state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    // Read data mux; d_out returns to 0 on every edge without a read.
    always_comb begin
        d_out_d = '0;
        if (rd_en) begin
            case (addr)
                A_RESULT: d_out_d = result_q;
                A_STATUS: d_out_d = status;
`ifdef BCDBIN_IRQ_EN
                A_IRQEN:  d_out_d = {31'd0, irq_en_q};
`endif
                default:  d_out_d = '0;
            endcase
        end
    end

    // State, register file and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            data_in_q <= '0;
            mode_q    <= 1'b0;
            wmode_q   <= 1'b0;
            bcd_q     <= '0;
            bin_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            d_out_q   <= '0;
        end else begin
            state_q   <= state_d;
            data_in_q <= data_in_d;
            mode_q    <= mode_d;
            wmode_q   <= wmode_d;
            bcd_q     <= bcd_d;
            bin_q     <= bin_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            done_q    <= done_d;
            err_q     <= err_d;
            d_out_q   <= d_out_d;
        end
    end

    assign d_out = d_out_q;

endmodule

// File: tb/tb_perip_bcd_bin_conv.sv
// Directed bench for perip_bcd_bin_conv (DIGITS=8, BIN_W=27).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_perip_bcd_bin_conv;
    localparam logic [4:0] A_DATA   = 5'h04;
    localparam logic [4:0] A_MODE   = 5'h08;
    localparam logic [4:0] A_CTRL   = 5'h0C;
    localparam logic [4:0] A_RESULT = 5'h10;
    localparam logic [4:0] A_STATUS = 5'h14;
    localparam logic [4:0] A_IRQEN  = 5'h18;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] d_in;
    logic        cs;
    logic [4:0]  addr;
    logic        rd;
    logic        wr;
    logic [31:0] d_out;
    logic        irq;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];

    perip_bcd_bin_conv #(.DIGITS(8), .BIN_W(27)) dut (
        .clk   (clk),
        .reset (reset),
        .d_in  (d_in),
        .cs    (cs),
        .addr  (addr),
        .rd    (rd),
        .wr    (wr),
        .d_out (d_out),
        .irq   (irq)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Driver tasks: all are entered and left on a falling edge.
    task automatic bus_write(input logic [4:0] a, input logic [31:0] v);
        cs = 1'b1; wr = 1'b1; addr = a; d_in = v;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0; addr = '0; d_in = '0;
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] v);
        cs = 1'b1; rd = 1'b1; addr = a;
        @(negedge clk);
        v = d_out;
        cs = 1'b0; rd = 1'b0; addr = '0;
    endtask

    // Start a conversion and keep reading STATUS until done shows up.
    // lat = edges from the start edge to the edge that set done (-1 on timeout).
    task automatic start_and_wait(output int lat, output logic [31:0] first_st,
                                  output logic [31:0] last_st);
        bus_write(A_CTRL, 32'h1);
        cs = 1'b1; rd = 1'b1; addr = A_STATUS;
        lat = -1; first_st = '0; last_st = '0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (c == 1) first_st = d_out;
            if (d_out[0]) begin
                lat = c - 1;
                last_st = d_out;
                break;
            end
        end
        cs = 1'b0; rd = 1'b0; addr = '0;
    endtask

    task automatic conv(input string tag, input logic mode, input logic [31:0] data,
                        input logic [31:0] exp_res, input logic exp_err);
        int          lat;
        logic [31:0] st0, st1, res;
        bus_write(A_MODE, {31'd0, mode});
        bus_write(A_DATA, data);
        start_and_wait(lat, st0, st1);
        check({tag, "_busy"}, st0, 32'h2);
        check({tag, "_lat"}, lat, exp_err ? 32'd2 : (mode ? 32'd29 : 32'd34));
        check({tag, "_status"}, st1, exp_err ? 32'h5 : 32'h1);
        bus_read(A_RESULT, res);
        check({tag, "_result"}, res, exp_res);
    endtask

    initial begin
        int          lat;
        logic [31:0] st0, st1, v;
        logic        v_mode[8];
        logic [31:0] v_data[8];

        reset = 1'b1; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; d_in = '0;
        repeat (3) @(negedge clk);
        check("rst_dout", d_out, 32'h0);
        check("rst_irq", irq, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        bus_read(A_STATUS, v);
        check("rst_status", v, 32'h0);
        bus_read(A_RESULT, v);
        check("rst_result", v, 32'h0);

        // Basic conversions in both directions and both error cases.
        conv("t1_bcd2bin", 1'b0, 32'h0001_2345, 32'h0000_3039, 1'b0);
        conv("t2_bin2bcd", 1'b1, 32'h0000_3039, 32'h0001_2345, 1'b0);
        conv("t2_bin2bcd_max", 1'b1, 32'h05F5_E0FF, 32'h9999_9999, 1'b0);
        conv("t3_bad_digit", 1'b0, 32'h0001_A345, 32'h0, 1'b0 | 1'b1);
        conv("t3_overflow", 1'b1, 32'h05F5_E100, 32'h0, 1'b1);

        // Operand and start writes during a conversion are ignored.
        bus_write(A_MODE, 32'h0);
        bus_write(A_DATA, 32'h0001_2345);
        bus_write(A_CTRL, 32'h1);
        repeat (8) @(negedge clk);
        bus_write(A_DATA, 32'h99);
        bus_write(A_CTRL, 32'h1);
        cs = 1'b1; rd = 1'b1; addr = A_STATUS;
        st1 = '0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (d_out[0]) begin
                st1 = d_out;
                break;
            end
        end
        cs = 1'b0; rd = 1'b0; addr = '0;
        check("t4_busy_status", st1, 32'h1);
        bus_read(A_RESULT, v);
        check("t4_busy_result", v, 32'h0000_3039);
        start_and_wait(lat, st0, st1);
        check("t4_rerun_lat", lat, 32'd34);
        bus_read(A_RESULT, v);
        check("t4_rerun_result", v, 32'h0000_3039);

        // Reset in the middle of a conversion.
        bus_write(A_CTRL, 32'h1);
        cs = 1'b1; rd = 1'b1; addr = A_STATUS;
        repeat (19) @(negedge clk);
        check("t4_pre_rst_busy", d_out, 32'h2);
        reset = 1'b1;
        #1;
        check("t4_rst_dout", d_out, 32'h0);
        cs = 1'b0; rd = 1'b0; addr = '0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        bus_read(A_STATUS, v);
        check("t4_rst_status", v, 32'h0);
        bus_read(A_RESULT, v);
        check("t4_rst_result", v, 32'h0);

        // Back-to-back runs checked against an expected-result queue.
        v_mode = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        v_data = '{32'h9999_9999, 32'h0000_0000, 32'h0000_0000, 32'h0000_0001,
                   32'h0000_0009, 32'h0000_0010, 32'h0098_9680, 32'h0000_0987};
        exp_q.push_back(32'h05F5_E0FF);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0001);
        exp_q.push_back(32'h0000_0009);
        exp_q.push_back(32'h0000_000A);
        exp_q.push_back(32'h1000_0000);
        exp_q.push_back(32'h0000_03DB);
        for (int i = 0; i < 8; i++)
            conv($sformatf("t5_b2b%0d", i), v_mode[i], v_data[i], exp_q.pop_front(), 1'b0);

        // Read qualification, unmapped offsets, read-only writes.
        cs = 1'b0; rd = 1'b1; addr = A_STATUS;
        @(negedge clk);
        check("t5_rd_no_cs", d_out, 32'h0);
        cs = 1'b1; rd = 1'b0;
        @(negedge clk);
        check("t5_cs_no_rd", d_out, 32'h0);
        cs = 1'b0; addr = '0;
        bus_read(5'h1C, v);
        check("t5_unmapped", v, 32'h0);
        bus_write(A_RESULT, 32'hDEAD_BEEF);
        bus_read(A_RESULT, v);
        check("t5_ro_write", v, 32'h0000_03DB);
        bus_read(A_STATUS, v);
        check("t5_status_sticky", v, 32'h1);

`ifdef BCDBIN_IRQ_EN
        bus_write(A_IRQEN, 32'h1);
        bus_write(A_MODE, 32'h0);
        bus_write(A_DATA, 32'h0001_2345);
        bus_write(A_CTRL, 32'h1);
        check("t6_irq_low", irq, 32'h0);
        lat = -1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (irq) begin
                lat = c;
                break;
            end
        end
        check("t6_irq_lat", lat, 32'd34);
        bus_read(A_STATUS, v);
        check("t6_irq_status", v, 32'h1);
        check("t6_irq_clr", irq, 32'h0);
        bus_write(A_IRQEN, 32'h0);
        conv("t6_noirq", 1'b0, 32'h0001_2345, 32'h0000_3039, 1'b0);
        check("t6_irq_off", irq, 32'h0);
`else
        conv("t6_noirq", 1'b0, 32'h0001_2345, 32'h0000_3039, 1'b0);
        check("t6_irq_tied", irq, 32'h0);
        bus_read(A_IRQEN, v);
        check("t6_irqen_rd", v, 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
